// File: rtl/stream_merge_arbiter.sv
// Merges NUM_CH FWFT FIFO outputs into one registered write stream with
// round-robin / fixed-priority arbitration, burst limit, packet hold and a saturating word counter.
module stream_merge_arbiter #(
  parameter int NUM_CH     = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_CH-1:0]            ENABLE_MASK,
  input  logic                         PRIO_MODE,
  input  logic [NUM_CH-1:0]            WRITE_REQ,
  input  logic [NUM_CH-1:0]            HOLD_REQ,
  input  logic [NUM_CH*DATA_WIDTH-1:0] DATA_IN,
  output logic [NUM_CH-1:0]            READ_GRANT,
  input  logic                         READY_OUT,
  output logic                         WRITE_OUT,
  output logic [DATA_WIDTH-1:0]        DATA_OUT,
  output logic                         ACTIVE,
  output logic [$clog2(NUM_CH)-1:0]    ACTIVE_CH,
  input  logic                         CLR_CNT,
  output logic [CNT_WIDTH-1:0]         WORD_CNT
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int BC_W = $clog2(MAX_BURST + 1);

  // Handshake: a channel word transfers in a cycle where READ_GRANT[i] is high
  // (its FIFO pops at that edge); READY_OUT high promises room for the word
  // that WRITE_OUT presents one cycle later.

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    act_ch_q, act_ch_d;
  logic [BC_W-1:0]    burst_q, burst_d, burst_inc;
  logic [NUM_CH-1:0]  eligible;
  logic               any_eligible;
  logic [CH_W-1:0]    rr_winner, prio_winner, winner;
  logic               pop;
  logic [DATA_WIDTH-1:0] sel_word;

  assign eligible     = WRITE_REQ & ENABLE_MASK;
  assign any_eligible = |eligible;

  // Scan downward so the last hit is the nearest channel after the last grant.
  always_comb begin : rr_pick
    logic [CH_W-1:0] idx;
    idx       = '0;
    rr_winner = act_ch_q;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = CH_W'((int'(act_ch_q) + k) % NUM_CH);
      if (eligible[idx]) rr_winner = idx;
    end
  end

  always_comb begin : prio_pick
    prio_winner = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (eligible[i]) prio_winner = CH_W'(i);
    end
  end

  assign winner = PRIO_MODE ? prio_winner : rr_winner;

  assign pop = (state_q == ST_GRANT) && eligible[act_ch_q] && READY_OUT;

  always_comb begin
    READ_GRANT = '0;
    if (pop) READ_GRANT[act_ch_q] = 1'b1;
  end

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (act_ch_q == CH_W'(i)) sel_word = DATA_IN[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign burst_inc = (burst_q == BC_W'(MAX_BURST)) ? burst_q : burst_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    act_ch_d = act_ch_q;
    burst_d  = burst_q;
    case (state_q)
      ST_IDLE: begin
        if (any_eligible) begin
          state_d  = ST_GRANT;
          act_ch_d = winner;
          burst_d  = '0;
        end
      end
      ST_GRANT: begin
        if (pop) burst_d = burst_inc;
        // A disabled channel loses the grant even mid-packet.
        if (!ENABLE_MASK[act_ch_q]) begin
          state_d = ST_IDLE;
        end else if (!HOLD_REQ[act_ch_q] && READY_OUT) begin
          if (!WRITE_REQ[act_ch_q] || (burst_inc >= BC_W'(MAX_BURST))) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      act_ch_q <= CH_W'(NUM_CH - 1);
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      act_ch_q <= act_ch_d;
      burst_q  <= burst_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      WRITE_OUT <= 1'b0;
      DATA_OUT  <= '0;
    end else begin
      WRITE_OUT <= pop;
      if (pop) DATA_OUT <= sel_word;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      WORD_CNT <= '0;
    end else if (CLR_CNT) begin
      WORD_CNT <= '0;
    end else if (WRITE_OUT && !(&WORD_CNT)) begin
      WORD_CNT <= WORD_CNT + 1'b1;
    end
  end

  assign ACTIVE    = (state_q == ST_GRANT);
  assign ACTIVE_CH = act_ch_q;

  grant_onehot0_a : assert property (@(posedge CLK) disable iff (RST) $onehot0(READ_GRANT));
  grant_eligible_a : assert property (@(posedge CLK) disable iff (RST)
    (READ_GRANT != '0) |-> ((READ_GRANT & eligible) == READ_GRANT) && READY_OUT);

endmodule

// File: tb/tb_stream_merge_arbiter.sv
// Bench for stream_merge_arbiter: FIFO models per channel, write-side scoreboard,
// table-driven burst-order vectors, hand sequences for hold/ready/mask/counter, random preloads.
module tb_stream_merge_arbiter;

  localparam int NUM_CH = 8;
  localparam int DW     = 32;
  localparam int MB     = 16;
  localparam int CW     = 8;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic [NUM_CH-1:0]    ENABLE_MASK, WRITE_REQ, HOLD_REQ, READ_GRANT;
  logic                 PRIO_MODE, READY_OUT, WRITE_OUT, ACTIVE, CLR_CNT;
  logic [NUM_CH*DW-1:0] DATA_IN;
  logic [DW-1:0]        DATA_OUT;
  logic [2:0]           ACTIVE_CH;
  logic [CW-1:0]        WORD_CNT;

  stream_merge_arbiter #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(CW)
  ) dut (
    .CLK(CLK), .RST(RST), .ENABLE_MASK(ENABLE_MASK), .PRIO_MODE(PRIO_MODE),
    .WRITE_REQ(WRITE_REQ), .HOLD_REQ(HOLD_REQ), .DATA_IN(DATA_IN),
    .READ_GRANT(READ_GRANT), .READY_OUT(READY_OUT), .WRITE_OUT(WRITE_OUT),
    .DATA_OUT(DATA_OUT), .ACTIVE(ACTIVE), .ACTIVE_CH(ACTIVE_CH),
    .CLR_CNT(CLR_CNT), .WORD_CNT(WORD_CNT)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: summary not reached in time");
    $fatal(1);
  end

  // ---------------- bench state ----------------
  logic [DW-1:0] fifo_q[NUM_CH][$];
  logic [DW-1:0] exp_q[$];
  int            pop_log[$];
  int            m_ch[$], m_len[$], o_ch[$], o_len[$];
  int            n_vec, n_err, wr_total, seq;

  typedef struct {
    int cnt[NUM_CH];
    bit prio;
    int nb;
    int exp_ch[4];
    int exp_len[4];
  } vec_t;
  vec_t vt[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_words(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      fifo_q[ch].push_back({8'(ch), 24'(seq)});
      seq++;
    end
  endtask

  function automatic bit pending_work();
    bit p = (exp_q.size() != 0);
    for (int i = 0; i < NUM_CH; i++)
      if (ENABLE_MASK[i] && fifo_q[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic reset_dut();
    RST = 1'b1; WRITE_REQ = '0; DATA_IN = '0; HOLD_REQ = '0; CLR_CNT = 1'b0;
    READY_OUT = 1'b1; ENABLE_MASK = '1; PRIO_MODE = 1'b0;
    for (int i = 0; i < NUM_CH; i++) fifo_q[i].delete();
    exp_q.delete(); pop_log.delete(); wr_total = 0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_write_out", WRITE_OUT, 0);
    check("rst_data_out", DATA_OUT, 0);
    check("rst_read_grant", READ_GRANT, 0);
    check("rst_active", ACTIVE, 0);
    check("rst_active_ch", ACTIVE_CH, NUM_CH - 1);
    check("rst_word_cnt", WORD_CNT, 0);
    RST = 1'b0;
  endtask

  // ---------------- driver: one clock of FIFO model + scoreboard ----------------
  task automatic cycle();
    int g;
    for (int i = 0; i < NUM_CH; i++) begin
      WRITE_REQ[i] = (fifo_q[i].size() != 0);
      DATA_IN[i*DW +: DW] = WRITE_REQ[i] ? fifo_q[i][0] : '0;
    end
    #1;
    check("grant_onehot0", $onehot0(READ_GRANT), 1);
    g = -1;
    for (int i = 0; i < NUM_CH; i++) if (READ_GRANT[i]) g = i;
    if (g >= 0) begin
      check("grant_legal", WRITE_REQ[g] && ENABLE_MASK[g] && READY_OUT, 1);
      if (fifo_q[g].size() != 0) exp_q.push_back(fifo_q[g].pop_front());
    end
    pop_log.push_back(g);
    @(posedge CLK);
    #1;
    check("write_strobe", WRITE_OUT, g >= 0);
    if (WRITE_OUT) begin
      wr_total++;
      if (exp_q.size() != 0) check("data_out", DATA_OUT, exp_q.pop_front());
      else check("write_without_pop", exp_q.size(), 1);
    end
  endtask

  task automatic drain(input bit rand_rdy);
    int cyc = 0;
    while (pending_work() && cyc < 3000) begin
      if (rand_rdy) READY_OUT = ($urandom_range(0, 3) != 0);
      cycle();
      cyc++;
    end
    READY_OUT = 1'b1;
    repeat (3) cycle();
    check("drain_done", pending_work(), 0);
  endtask

  // ---------------- reference model: burst sequence from preloaded counts ----------------
  function automatic void model_bursts(input int cnt[NUM_CH], input bit prio,
                                       input logic [NUM_CH-1:0] mask);
    int c[NUM_CH];
    int last, w, n;
    c = cnt;
    last = NUM_CH - 1;
    m_ch.delete(); m_len.delete();
    for (int guard = 0; guard < 1000; guard++) begin
      w = -1;
      for (int k = 0; k < NUM_CH; k++) begin
        int j = prio ? k : (last + 1 + k) % NUM_CH;
        if (w < 0 && c[j] > 0 && mask[j]) w = j;
      end
      if (w < 0) break;
      n = (c[w] < MB) ? c[w] : MB;
      c[w] -= n;
      m_ch.push_back(w);
      m_len.push_back(n);
      last = w;
    end
  endfunction

  function automatic void extract_bursts();
    int prev = -1;
    o_ch.delete(); o_len.delete();
    foreach (pop_log[k]) begin
      if (pop_log[k] < 0) prev = -1;
      else if (pop_log[k] == prev) o_len[o_len.size() - 1]++;
      else begin
        o_ch.push_back(pop_log[k]);
        o_len.push_back(1);
        prev = pop_log[k];
      end
    end
  endfunction

  task automatic run_scenario(input int cnt[NUM_CH], input bit prio,
                              input logic [NUM_CH-1:0] mask, input bit rand_rdy);
    int sum = 0;
    reset_dut();
    PRIO_MODE = prio;
    ENABLE_MASK = mask;
    for (int i = 0; i < NUM_CH; i++) begin
      push_words(i, cnt[i]);
      if (mask[i]) sum += cnt[i];
    end
    drain(rand_rdy);
    if (!rand_rdy) begin
      extract_bursts();
      check("burst_count", o_ch.size(), m_ch.size());
      for (int b = 0; b < m_ch.size() && b < o_ch.size(); b++) begin
        check("burst_ch", o_ch[b], m_ch[b]);
        check("burst_len", o_len[b], m_len[b]);
      end
    end
    check("word_cnt", WORD_CNT, (sum < 255) ? sum : 255);
  endtask

  // ---------------- test ----------------
  initial begin
    int rc[NUM_CH];
    int nz[$];
    logic [11:0] rdy_pat;
    bit have, found;
    int base;

    n_vec = 0; n_err = 0; seq = 0; wr_total = 0;

    vt[0].cnt = '{3, 3, 3, 3, 0, 0, 0, 0}; vt[0].prio = 0; vt[0].nb = 4;
    vt[0].exp_ch = '{0, 1, 2, 3};          vt[0].exp_len = '{3, 3, 3, 3};
    vt[1].cnt = '{0, 40, 5, 0, 0, 0, 0, 0}; vt[1].prio = 0; vt[1].nb = 4;
    vt[1].exp_ch = '{1, 2, 1, 1};           vt[1].exp_len = '{16, 5, 16, 8};
    vt[2].cnt = '{20, 0, 0, 0, 0, 4, 0, 0}; vt[2].prio = 1; vt[2].nb = 3;
    vt[2].exp_ch = '{0, 0, 5, 0};           vt[2].exp_len = '{16, 4, 4, 0};
    vt[3].cnt = '{1, 0, 0, 0, 0, 0, 0, 2};  vt[3].prio = 0; vt[3].nb = 2;
    vt[3].exp_ch = '{0, 7, 0, 0};           vt[3].exp_len = '{1, 2, 0, 0};
    vt[4].cnt = '{20, 2, 0, 0, 0, 0, 0, 0}; vt[4].prio = 0; vt[4].nb = 3;
    vt[4].exp_ch = '{0, 1, 0, 0};           vt[4].exp_len = '{16, 2, 4, 0};

    for (int v = 0; v < 5; v++) begin
      m_ch.delete(); m_len.delete();
      for (int b = 0; b < vt[v].nb; b++) begin
        m_ch.push_back(vt[v].exp_ch[b]);
        m_len.push_back(vt[v].exp_len[b]);
      end
      run_scenario(vt[v].cnt, vt[v].prio, '1, 1'b0);
      check("idle_bubble", {pop_log[0] < 0, pop_log[1] >= 0}, 2'b11);
    end

    // Hold on ch3: empties twice, refills, ch4 waits until hold drops.
    reset_dut();
    HOLD_REQ = 8'b0000_1000;
    push_words(3, 2);
    push_words(4, 2);
    for (int k = 0; k < 28; k++) begin
      if (k == 6) push_words(3, 3);
      if (k == 12) push_words(3, 15);
      cycle();
      check("hold_keeps_ch3", {ACTIVE, ACTIVE_CH}, {1'b1, 3'd3});
    end
    HOLD_REQ = '0;
    drain(1'b0);
    nz.delete();
    foreach (pop_log[k]) if (pop_log[k] >= 0) nz.push_back(pop_log[k]);
    check("hold_pop_total", nz.size(), 22);
    foreach (nz[k]) check("hold_pop_order", nz[k], (k < 20) ? 3 : 4);

    // READY_OUT stalls mid-burst.
    reset_dut();
    push_words(2, 6);
    rdy_pat = 12'b1111_1011_0011;
    for (int k = 0; k < 12; k++) begin
      READY_OUT = rdy_pat[k];
      have = (fifo_q[2].size() != 0);
      cycle();
      check("ready_pop", pop_log[$] >= 0, READY_OUT && have && (k >= 1));
    end
    READY_OUT = 1'b1;
    drain(1'b0);
    check("ready_word_cnt", WORD_CNT, 6);

    // Mask removal during a held grant.
    reset_dut();
    HOLD_REQ = 8'b0000_0100;
    push_words(2, 10);
    repeat (3) cycle();
    ENABLE_MASK[2] = 1'b0;
    cycle();
    check("mask_no_grant", pop_log[$], -1);
    check("mask_to_idle", ACTIVE, 0);
    repeat (2) cycle();
    check("mask_stays_idle", {ACTIVE, READ_GRANT}, 0);
    check("mask_word_cnt", WORD_CNT, 2);

    // Counter saturation, then clear colliding with a write.
    reset_dut();
    push_words(0, 260);
    drain(1'b0);
    check("cnt_saturated", WORD_CNT, 255);
    push_words(1, 4);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (WRITE_OUT) found = 1'b1;
    end
    check("clr_write_seen", found, 1);
    base = wr_total;
    CLR_CNT = 1'b1;
    cycle();
    CLR_CNT = 1'b0;
    check("clr_priority", WORD_CNT, 0);
    drain(1'b0);
    check("cnt_after_clr", WORD_CNT, wr_total - base);

    // Random preloads: mode, mask and counts against the burst model.
    for (int r = 0; r < 6; r++) begin
      logic [NUM_CH-1:0] msk;
      bit pm;
      for (int i = 0; i < NUM_CH; i++) rc[i] = $urandom_range(0, 24);
      pm  = $urandom_range(0, 1);
      msk = NUM_CH'($urandom_range(1, 255));
      model_bursts(rc, pm, msk);
      run_scenario(rc, pm, msk, 1'b0);
    end

    // Random READY_OUT: integrity and totals only.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM_CH; i++) rc[i] = $urandom_range(0, 20);
      run_scenario(rc, r[0], '1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
